// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path and the future receive block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    CAPT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_e;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int CLKS_PER_BIT_DEFAULT = 10;
  localparam int DATA_W_DEFAULT       = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-period timer: bit_end marks the last clk of every bit period while running.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends each one as an 8N1 UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              tx_q;
  logic              bit_end;
  logic              timing;
  logic              pop_ok;

  // The baud timer only runs while a bit is on the line, so START always begins at count 0.
  assign timing = (state == START) || (state == DATA) || (state == STOP);
  assign pop_ok = en && !fifo_empty;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(!timing),
    .bit_end(bit_end)
  );

  // NOTE: the shift register is a plain datapath register, but it is cleared on reset so a discarded byte never lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_q    <= TX_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_ok) state <= POP;
        end
        POP: begin
          state <= CAPT;
        end
        CAPT: begin
          shreg <= fifo_data;
          tx_q  <= START_BIT;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          // tx is loaded one edge ahead so the line changes exactly on the bit boundary.
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              tx_q  <= STOP_BIT;
              state <= STOP;
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) state <= pop_ok ? POP : IDLE;
        end
        default: begin
          state <= IDLE;
          tx_q  <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign fifo_rd   = (state == POP);
  assign busy      = (state != IDLE);
  assign byte_done = (state == STOP) && bit_end;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 8-bit synchronous FIFO. It pops one byte at a time whenever the FIFO is non-empty and enabled, and serialises each byte as an 8N1 UART frame on a single line. It sits between the FIFO's read side (rd/empty/data_out) and the chip's serial TX pin. It provides byte-completion and busy status for the surrounding control logic.

Parameters:
CLKS_PER_BIT, 10, clk cycles per UART bit; legal range >= 2.
DATA_W, 8, frame payload width; must match the FIFO data width.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  allows new bytes to be popped; does not abort a frame already in flight.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_W  FIFO data_out; registered, valid the cycle after rd is sampled.
fifo_rd  output  1  FIFO read strobe; one-cycle pulse per byte.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
byte_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high. No other resets and no async logic.
- Reset values (cycle after `rst` is sampled high): state IDLE, tx=1, fifo_rd=0, busy=0, byte_done=0. The bit counter, baud counter, and shift register are cleared.
- FSM states: IDLE, POP, CAPT, START, DATA, STOP.
- IDLE:
  - If en && !fifo_empty, go to POP.
  - Otherwise stay in IDLE with tx=1.
- POP (1 cycle): fifo_rd=1 (decoded from state). Then go to CAPT.
- CAPT (1 cycle): latch fifo_data into the shift register at the end of the cycle. tx stays 1. Then go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA: DATA_W bits, LSB first, each held for exactly CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - byte_done=1 in the final STOP cycle.
  - Next state: POP if en && !fifo_empty in that cycle, else IDLE.
- tx is registered, so it is glitch-free.
- Latency:
  - Condition seen in IDLE at cycle 0: fifo_rd high in cycle 1, first tx=0 in cycle 3.
  - Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 2 extra tx-high cycles (POP+CAPT) between the stop bit and the next start bit.
- Counters:
  - The baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - The bit index is $clog2(DATA_W) bits.
  - No wrap beyond the terminal values.
- Boundary conditions:
  - fifo_empty is sampled only in IDLE and in the last STOP cycle. It is never popped when empty, so FIFO underflow is impossible by construction.
  - en deasserted mid-frame: the current frame completes, including byte_done; then go to IDLE.
  - en/empty changing during POP/CAPT: ignored; the popped byte is always transmitted.
  - rst mid-frame: the next cycle has tx=1 and busy=0, byte_done is not pulsed, and the popped byte is discarded.
  - rst and fifo_rd in the same cycle: rst wins, and fifo_rd is 0 from the next cycle.
  - fifo_rd is never high for more than 1 consecutive cycle.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE, POP, CAPT, START, DATA, STOP);
  - localparams TX_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1;
  - default CLKS_PER_BIT.
- One natural sub-module, `uart_bit_timer`: parameter CLKS_PER_BIT; inputs clk, rst, restart; output bit_end. bit_end pulses on the last cycle of each bit period. It is reused by the future RX block.
- The FSM, shift register, and bit index stay in fifo_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO model with 1-cycle registered read):
1. Assert rst for 2 cycles with en=1 and fifo_empty=0 -> during and after reset, tx=1, busy=0, fifo_rd=0, byte_done=0, with no rd pulse until the cycle after rst drops.
2. FIFO holds 8'h11, en=1 -> a single fifo_rd pulse, then tx = 0, then 1,0,0,0,1,0,0,0, then 1, each held 4 cycles; 40 cycles from first tx=0 to the end of stop; byte_done pulses once; state returns to IDLE.
3. FIFO holds 11,22,33,44,11,22,33,44 -> 8 rd pulses and 8 frames in order; exactly 2 tx-high cycles between each stop end and the next start; busy stays high throughout; FIFO ends empty with no pop while empty.
4. en=0 with a non-empty FIFO for 50 cycles -> no fifo_rd and tx=1. Then drop en during the DATA bit 3 of byte 8'h33 -> the frame completes and byte_done pulses, with no further fifo_rd.
5. rst for one cycle during DATA bit 5 of byte 8'h44 -> tx=1 and busy=0 the next cycle, no byte_done, and the byte is not re-sent. After reset, the next FIFO byte transmits correctly.
6. FIFO empty for 100 cycles with en=1 -> the block stays idle (tx=1, busy=0, fifo_rd=0). Then write 8'hA5 -> rd occurs 1 cycle after empty deasserts, and the frame is 0,1,0,1,0,0,1,0,1,1.
